// File: rtl/flash_rd_seq_pkg.sv
// rtl/flash_rd_seq_pkg.sv - shared opcodes, bus formats and state encodings for the flash read sequencer
package flash_rd_seq_pkg;

    // Flash read opcodes
    localparam logic [7:0] CMD_READ_SDR  = 8'h03;
    localparam logic [7:0] CMD_READ_QUAD = 8'hEB;

    // Byte engine bus formats; FMT_OFF deasserts CS#
    localparam logic [2:0] FMT_OFF   = 3'b000;
    localparam logic [2:0] FMT_SDR_T = 3'b010;
    localparam logic [2:0] FMT_SDR_R = 3'b011;
    localparam logic [2:0] FMT_DDR_T = 3'b100;
    localparam logic [2:0] FMT_QDR_T = 3'b110;
    localparam logic [2:0] FMT_QDR_R = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_MODE,
        ST_DUMMY,
        ST_DATA,
        ST_CSH
    } state_e;

    // Sub-phase of a byte slot: ISSUE is the f_wr cycle, WAIT0 is the
    // cycle in which f_ready is still stale, WAIT polls f_ready.
    typedef enum logic [1:0] {
        PH_ISSUE,
        PH_WAIT0,
        PH_WAIT
    } phase_e;

    // Address bytes go out MSB first; idx 0 selects bits [23:16].
    function automatic logic [7:0] addr_byte(input logic [23:0] a, input logic [1:0] idx);
        case (idx)
            2'd0:    return a[23:16];
            2'd1:    return a[15:8];
            default: return a[7:0];
        endcase
    endfunction

endpackage

// File: rtl/flash_rd_seq.sv
// rtl/flash_rd_seq.sv - read sequencer driving the SPI flash byte engine through one read transaction
//
// Accepts one read request (addr, len, SDR/quad) and walks the engine through
// command, address, [mode, dummy,] data bytes, then holds CS# high for
// CSH_CYCLES before returning to idle.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   start/quad/addr/len/prescale  request, sampled in IDLE
//   abort                      stop after the byte in flight
//   busy, done                 transaction in progress / one-cycle end pulse
//   rdata, rvalid              received data strobe stream
//   f_ready, f_dout            engine byte-complete and received byte
//   f_wr, f_din, f_format, f_prescale  engine controls (all registered)
module flash_rd_seq
    import flash_rd_seq_pkg::*;
#(
    parameter int CSH_CYCLES = 4,
    parameter int LEN_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             quad,
    input  logic [23:0]      addr,
    input  logic [LEN_W-1:0] len,
    input  logic [3:0]       prescale,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [7:0]       rdata,
    output logic             rvalid,
    input  logic             f_ready,
    input  logic [7:0]       f_dout,
    output logic             f_wr,
    output logic [7:0]       f_din,
    output logic [2:0]       f_format,
    output logic [3:0]       f_prescale
);

    localparam int CSH_W = (CSH_CYCLES > 1) ? $clog2(CSH_CYCLES) : 1;

    state_e           state_q;
    phase_e           phase_q;
    logic [1:0]       idx_q;
    logic             quad_q;
    logic [23:0]      addr_q;
    logic [LEN_W-1:0] cnt_q;
    logic             abort_q;
    logic [CSH_W-1:0] csh_q;

    logic             busy_q;
    logic             done_q;
    logic             rvalid_q;
    logic [7:0]       rdata_q;
    logic             f_wr_q;
    logic [7:0]       f_din_q;
    logic [2:0]       f_format_q;
    logic [3:0]       f_prescale_q;

    // Slot that follows the current one once its byte completes
    state_e           nxt_state_d;
    logic [1:0]       nxt_idx_d;
    logic [7:0]       nxt_din_d;
    logic [2:0]       nxt_fmt_d;

    assign busy       = busy_q;
    assign done       = done_q;
    assign rvalid     = rvalid_q;
    assign rdata      = rdata_q;
    assign f_wr       = f_wr_q;
    assign f_din      = f_din_q;
    assign f_format   = f_format_q;
    assign f_prescale = f_prescale_q;

    always_comb begin
        nxt_state_d = ST_CSH;
        nxt_idx_d   = 2'd0;
        nxt_din_d   = 8'hFF;
        nxt_fmt_d   = FMT_OFF;
        case (state_q)
            ST_CMD: begin
                nxt_state_d = ST_ADDR;
                nxt_din_d   = addr_byte(addr_q, 2'd0);
                nxt_fmt_d   = quad_q ? FMT_QDR_T : FMT_SDR_T;
            end
            ST_ADDR: begin
                if (idx_q != 2'd2) begin
                    nxt_state_d = ST_ADDR;
                    nxt_idx_d   = idx_q + 2'd1;
                    nxt_din_d   = addr_byte(addr_q, idx_q + 2'd1);
                    nxt_fmt_d   = quad_q ? FMT_QDR_T : FMT_SDR_T;
                end else if (quad_q) begin
                    nxt_state_d = ST_MODE;
                    nxt_din_d   = 8'h00;
                    nxt_fmt_d   = FMT_QDR_T;
                end else begin
                    nxt_state_d = ST_DATA;
                    nxt_fmt_d   = FMT_SDR_R;
                end
            end
            ST_MODE: begin
                nxt_state_d = ST_DUMMY;
                nxt_fmt_d   = FMT_QDR_R;
            end
            ST_DUMMY: begin
                nxt_state_d = (idx_q == 2'd0) ? ST_DUMMY : ST_DATA;
                nxt_idx_d   = 2'd1;
                nxt_fmt_d   = FMT_QDR_R;
            end
            ST_DATA: begin
                // cnt_q still counts the byte completing now
                if (cnt_q != LEN_W'(1)) begin
                    nxt_state_d = ST_DATA;
                    nxt_fmt_d   = quad_q ? FMT_QDR_R : FMT_SDR_R;
                end
            end
            default: begin
            end
        endcase
        // An abort seen now or latched earlier wins over any further byte
        if (abort || abort_q) begin
            nxt_state_d = ST_CSH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            phase_q      <= PH_ISSUE;
            idx_q        <= 2'd0;
            quad_q       <= 1'b0;
            addr_q       <= 24'd0;
            cnt_q        <= '0;
            abort_q      <= 1'b0;
            csh_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= 8'd0;
            f_wr_q       <= 1'b0;
            f_din_q      <= 8'd0;
            f_format_q   <= FMT_OFF;
            f_prescale_q <= 4'd0;
        end else begin
            f_wr_q   <= 1'b0;
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && (len != '0)) begin
                        state_q      <= ST_CMD;
                        phase_q      <= PH_ISSUE;
                        idx_q        <= 2'd0;
                        quad_q       <= quad;
                        addr_q       <= addr;
                        cnt_q        <= len;
                        abort_q      <= 1'b0;
                        busy_q       <= 1'b1;
                        f_prescale_q <= prescale;
                        f_wr_q       <= 1'b1;
                        f_din_q      <= quad ? CMD_READ_QUAD : CMD_READ_SDR;
                        f_format_q   <= FMT_SDR_T;
                    end
                end
                ST_CSH: begin
                    if (csh_q == CSH_W'(CSH_CYCLES - 1)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        csh_q <= csh_q + CSH_W'(1);
                    end
                end
                default: begin
                    if (abort) begin
                        abort_q <= 1'b1;
                    end
                    case (phase_q)
                        PH_ISSUE: phase_q <= PH_WAIT0;
                        PH_WAIT0: phase_q <= PH_WAIT;
                        default: begin
                            if (f_ready) begin
                                if (state_q == ST_DATA) begin
                                    rvalid_q <= 1'b1;
                                    rdata_q  <= f_dout;
                                    cnt_q    <= cnt_q - LEN_W'(1);
                                end
                                if (nxt_state_d == ST_CSH) begin
                                    state_q    <= ST_CSH;
                                    f_format_q <= FMT_OFF;
                                    csh_q      <= '0;
                                end else begin
                                    state_q    <= nxt_state_d;
                                    idx_q      <= nxt_idx_d;
                                    phase_q    <= PH_ISSUE;
                                    f_wr_q     <= 1'b1;
                                    f_din_q    <= nxt_din_d;
                                    f_format_q <= nxt_fmt_d;
                                end
                            end
                        end
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_rd_seq.sv
// tb/tb_flash_rd_seq.sv - self-checking bench for flash_rd_seq with a behavioural byte engine
module tb_flash_rd_seq;

    localparam int CSH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        quad = 1'b0;
    logic [23:0] addr = 24'd0;
    logic [15:0] len = 16'd0;
    logic [3:0]  prescale = 4'd0;
    logic        abort = 1'b0;
    logic        busy, done, rvalid, f_wr;
    logic [7:0]  rdata, f_din;
    logic [2:0]  f_format;
    logic [3:0]  f_prescale;
    logic        f_ready = 1'b1;
    logic [7:0]  f_dout = 8'd0;

    int errors = 0;
    int checks = 0;

    // Byte engine model state
    int          eng_bt = 3;
    int          eng_base = 0;
    int          eng_wr_cnt = 0;
    int          eng_left = 0;
    logic [7:0]  rx_mem [0:63];

    flash_rd_seq #(.CSH_CYCLES(CSH), .LEN_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .quad(quad), .addr(addr),
        .len(len), .prescale(prescale), .abort(abort), .busy(busy),
        .done(done), .rdata(rdata), .rvalid(rvalid), .f_ready(f_ready),
        .f_dout(f_dout), .f_wr(f_wr), .f_din(f_din), .f_format(f_format),
        .f_prescale(f_prescale)
    );

    always #5 clk = ~clk;

    // Engine: ready drops the cycle after wr, returns after eng_bt cycles
    // with the byte for slot k of the current transaction.
    always @(posedge clk) begin
        if (f_wr) begin
            f_ready    <= 1'b0;
            eng_left   <= eng_bt - 1;
            eng_wr_cnt <= eng_wr_cnt + 1;
        end else if (!f_ready) begin
            if (eng_left <= 0) begin
                f_ready <= 1'b1;
                f_dout  <= rx_mem[6'(eng_wr_cnt - 1 - eng_base)];
            end else begin
                eng_left <= eng_left - 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_txn(input string nm, input bit q, input logic [23:0] a, input int n,
                           input logic [3:0] ps, input int bt, input int ak, input bit chg_ps,
                           input bit sdb, input bit fixed, input logic [7:0] d0, input logic [7:0] d1,
                           output int o_nb, output int o_nrv, output logic [7:0] o_rd0,
                           output logic [7:0] o_rd1);
        logic [7:0] g_din[$], e_din[$], g_rv[$], e_rv[$];
        logic [2:0] g_fmt[$], e_fmt[$];
        bit         e_chk[$];
        int hdr, ndel, first_wr, done_cyc, last_rv, ndone, csh_n, fmt_viol, ps_viol, wr_dbl, abort_arm, nb;
        logic busy1, busy_done, prev_wr;
        logic [2:0] prev_fmt;
        hdr  = q ? 7 : 4;
        ndel = (ak > 0 && ak < n) ? ak : n;
        // Reference byte stream of the transaction
        e_din.push_back(q ? 8'hEB : 8'h03); e_fmt.push_back(3'b010); e_chk.push_back(1'b1);
        for (int i = 0; i < 3; i++) begin
            e_din.push_back(a[23-8*i -: 8]); e_fmt.push_back(q ? 3'b110 : 3'b010); e_chk.push_back(1'b1);
        end
        if (q) begin
            e_din.push_back(8'h00); e_fmt.push_back(3'b110); e_chk.push_back(1'b1);
            for (int i = 0; i < 2; i++) begin
                e_din.push_back(8'h00); e_fmt.push_back(3'b111); e_chk.push_back(1'b0);
            end
        end
        for (int i = 0; i < ndel; i++) begin
            e_din.push_back(8'hFF); e_fmt.push_back(q ? 3'b111 : 3'b011); e_chk.push_back(1'b1);
        end
        for (int i = 0; i < 64; i++) rx_mem[i] = 8'($urandom);
        if (fixed) begin
            rx_mem[hdr] = d0;
            rx_mem[hdr+1] = d1;
        end
        for (int i = 0; i < ndel; i++) e_rv.push_back(rx_mem[hdr+i]);

        eng_bt = bt; eng_base = eng_wr_cnt;
        start = 1'b1; quad = q; addr = a; len = 16'(n); prescale = ps;
        first_wr = -1; done_cyc = -1; last_rv = -1; ndone = 0; csh_n = 0;
        fmt_viol = 0; ps_viol = 0; wr_dbl = 0; abort_arm = -1;
        busy1 = 1'b0; busy_done = 1'b1; prev_wr = 1'b0; prev_fmt = f_format;
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            @(negedge clk);
            abort = (cyc == abort_arm);
            if (cyc == 1) begin start = 1'b0; busy1 = busy; end
            if (chg_ps) prescale = 4'($urandom);
            if (sdb && cyc == 6) begin start = 1'b1; len = 16'(n + 7); addr = ~a; quad = ~q; end
            if (sdb && cyc == 7) start = 1'b0;
            if (f_wr) begin
                if (first_wr < 0) first_wr = cyc;
                if (prev_wr) wr_dbl++;
                g_din.push_back(f_din); g_fmt.push_back(f_format);
                if (ak > 0 && g_din.size() == hdr + ak) abort_arm = cyc + 1;
            end
            if (f_format != prev_fmt && f_format != 3'b000 && !f_wr) fmt_viol++;
            if (busy && f_format == 3'b000) csh_n++;
            if (busy && f_prescale != ps) ps_viol++;
            if (rvalid) begin g_rv.push_back(rdata); last_rv = cyc; end
            if (done) begin
                ndone++;
                if (done_cyc < 0) begin done_cyc = cyc; busy_done = busy; end
            end
            prev_fmt = f_format; prev_wr = f_wr;
            if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
        end
        abort = 1'b0;

        chk($sformatf("%s done_seen", nm), int'(done_cyc >= 0), 1);
        chk($sformatf("%s first_wr_cycle", nm), first_wr, 1);
        chk($sformatf("%s busy_after_start", nm), int'(busy1), 1);
        nb = g_din.size();
        chk($sformatf("%s nbytes", nm), nb, e_din.size());
        for (int i = 0; i < nb && i < e_din.size(); i++) begin
            if (e_chk[i]) chk($sformatf("%s din[%0d]", nm, i), int'(g_din[i]), int'(e_din[i]));
            chk($sformatf("%s fmt[%0d]", nm, i), int'(g_fmt[i]), int'(e_fmt[i]));
        end
        chk($sformatf("%s nrvalid", nm), g_rv.size(), e_rv.size());
        for (int i = 0; i < g_rv.size() && i < e_rv.size(); i++)
            chk($sformatf("%s rdata[%0d]", nm, i), int'(g_rv[i]), int'(e_rv[i]));
        chk($sformatf("%s ndone", nm), ndone, 1);
        chk($sformatf("%s busy_at_done", nm), int'(busy_done), 0);
        if (last_rv >= 0 && done_cyc >= 0)
            chk($sformatf("%s done_after_rvalid", nm), done_cyc - last_rv, CSH);
        chk($sformatf("%s csh_cycles", nm), csh_n, CSH);
        chk($sformatf("%s fmt_outside_issue", nm), fmt_viol, 0);
        chk($sformatf("%s wr_multi_cycle", nm), wr_dbl, 0);
        chk($sformatf("%s prescale_hold", nm), ps_viol, 0);
        o_nb = nb;
        o_nrv = g_rv.size();
        o_rd0 = (g_rv.size() > 0) ? g_rv[0] : 8'h00;
        o_rd1 = (g_rv.size() > 1) ? g_rv[1] : 8'h00;
    endtask

    typedef struct {
        bit          q;
        logic [23:0] a;
        int          n;
        int          bt;
        int          ak;
        bit          chg;
        bit          sdb;
        logic [7:0]  d0;
        logic [7:0]  d1;
        int          exp_nb;
        int          exp_nrv;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int nb, nrv, nwr, nbusy, nd, nw;
        logic [7:0] rd0, rd1;
        bit hit;

        tbl[0] = '{1'b0, 24'h012345, 2,  3, 0, 1'b0, 1'b0, 8'hA5, 8'h5A, 6, 2};
        tbl[1] = '{1'b1, 24'hFFFFFF, 1,  2, 0, 1'b0, 1'b0, 8'h3C, 8'h00, 8, 1};
        tbl[2] = '{1'b0, 24'h000100, 10, 4, 3, 1'b0, 1'b0, 8'h11, 8'h22, 7, 3};
        tbl[3] = '{1'b1, 24'h000000, 3,  1, 0, 1'b0, 1'b0, 8'hC3, 8'h7E, 10, 3};
        tbl[4] = '{1'b0, 24'h800001, 1,  5, 1, 1'b0, 1'b0, 8'h99, 8'h00, 5, 1};
        tbl[5] = '{1'b1, 24'hABCDEF, 4,  3, 2, 1'b1, 1'b1, 8'h01, 8'hFE, 9, 2};
        tbl[6] = '{1'b0, 24'h5A5A5A, 5,  2, 0, 1'b1, 1'b1, 8'h80, 8'h7F, 9, 5};

        // Reset values
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst rvalid", int'(rvalid), 0);
        chk("rst rdata", int'(rdata), 0);
        chk("rst f_wr", int'(f_wr), 0);
        chk("rst f_din", int'(f_din), 0);
        chk("rst f_format", int'(f_format), 0);
        chk("rst f_prescale", int'(f_prescale), 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 7; i++) begin
            run_txn($sformatf("vec%0d", i), tbl[i].q, tbl[i].a, tbl[i].n, 4'(i + 3), tbl[i].bt,
                    tbl[i].ak, tbl[i].chg, tbl[i].sdb, 1'b1, tbl[i].d0, tbl[i].d1,
                    nb, nrv, rd0, rd1);
            chk($sformatf("vec%0d table_nbytes", i), nb, tbl[i].exp_nb);
            chk($sformatf("vec%0d table_nrvalid", i), nrv, tbl[i].exp_nrv);
            if (tbl[i].exp_nrv >= 1) chk($sformatf("vec%0d table_rd0", i), int'(rd0), int'(tbl[i].d0));
            if (tbl[i].exp_nrv >= 2) chk($sformatf("vec%0d table_rd1", i), int'(rd1), int'(tbl[i].d1));
        end

        // len = 0 request is ignored
        start = 1'b1; quad = 1'b0; addr = 24'h001234; len = 16'd0; prescale = 4'h7;
        nwr = 0; nbusy = 0; nd = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            if (f_wr) nwr++;
            if (busy) nbusy++;
            if (done) nd++;
        end
        chk("len0 f_wr", nwr, 0);
        chk("len0 busy", nbusy, 0);
        chk("len0 done", nd, 0);

        // Reset during the first address byte
        eng_bt = 3; eng_base = eng_wr_cnt;
        start = 1'b1; quad = 1'b0; addr = 24'h123456; len = 16'd4; prescale = 4'h5;
        nw = 0; hit = 1'b0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            if (f_wr) nw++;
            if (f_wr && nw == 2) begin hit = 1'b1; break; end
        end
        chk("rstaddr reached_addr", int'(hit), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstaddr f_format", int'(f_format), 0);
        chk("rstaddr busy", int'(busy), 0);
        chk("rstaddr f_wr", int'(f_wr), 0);
        chk("rstaddr f_prescale", int'(f_prescale), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        run_txn("post_rst", 1'b0, 24'h00ABCD, 3, 4'h9, 2, 0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00,
                nb, nrv, rd0, rd1);

        // Randomized transactions against the reference stream
        for (int r = 0; r < 20; r++) begin
            bit   rq, rchg, rsdb;
            int   rn, rbt, rak;
            logic [23:0] ra;
            rq   = 1'($urandom_range(0, 1));
            ra   = 24'($urandom);
            rn   = $urandom_range(1, 12);
            rbt  = $urandom_range(1, 5);
            rak  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, rn) : 0;
            rchg = 1'($urandom_range(0, 1));
            rsdb = 1'($urandom_range(0, 1));
            run_txn($sformatf("rnd%0d", r), rq, ra, rn, 4'($urandom), rbt, rak, rchg, rsdb,
                    1'b0, 8'h00, 8'h00, nb, nrv, rd0, rd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/flash_rd_seq.md
# flash_rd_seq

Read sequencer for the SPI flash byte engine. It accepts a single read request (start address, byte count, SDR or quad mode) and drives the engine's byte handshake through the full flash transaction. For SDR that is command, address and data; quad mode adds mode and dummy bytes. Received data is delivered as a one-cycle strobe stream. It sits between the CPU/boot-loader fetch logic and the byte engine, and is the only master of the engine's `wr/din/format/prescale` inputs.

## Interface
- `CSH_CYCLES`, default 4: clk cycles that `f_format` is held at 3'b000 (CS# high) after each transaction.
- `LEN_W`, default 16: width of the byte-count field.

- `clk`  in  1  system clock
- `rst`  in  1  synchronous reset, active high
- `start`  in  1  request strobe; sampled only in IDLE
- `quad`  in  1  0 = SDR read 0x03, 1 = quad I/O read 0xEB
- `addr`  in  24  flash byte address, sampled with `start`
- `len`  in  LEN_W  number of bytes to read; 0 = request ignored
- `prescale`  in  4  SCLK divisor, sampled with `start`
- `abort`  in  1  end the transaction after the byte in flight
- `busy`  out  1  high from accepted `start` through end of CS-high time
- `done`  out  1  one-cycle pulse when returning to IDLE
- `rdata`  out  8  received byte
- `rvalid`  out  1  one-cycle strobe, `rdata` valid
- `f_ready`  in  1  engine ready / byte complete
- `f_dout`  in  8  engine received byte
- `f_wr`  out  1  engine transmit strobe
- `f_din`  out  8  engine transmit byte
- `f_format`  out  3  engine bus format
- `f_prescale`  out  4  engine prescale, registered copy

## Operation
- Reset values:
  - `busy`=0, `done`=0, `rvalid`=0, `rdata`=0.
  - `f_wr`=0, `f_din`=0, `f_format`=3'b000, `f_prescale`=0.
  - State IDLE.
- States and the byte each one sends:
  - **IDLE**
  - **CMD**: 0x03 or 0xEB, format 010.
  - **ADDR**: 3 bytes, MSB first. SDR uses format 010; quad uses 110.
  - **MODE**: quad only; 0x00, format 110.
  - **DUMMY**: quad only; 2 bytes, format 111, received data discarded.
  - **DATA**: `din`=0xFF. SDR uses format 011; quad uses 111.
  - **CSH**: format 000 for `CSH_CYCLES` cycles.
  - Then back to IDLE.
- Every non-IDLE/CSH state runs a two-phase byte slot:
  - ISSUE: assert `f_wr` for exactly 1 cycle with `f_din`/`f_format` valid in the same cycle, then go to WAIT.
  - WAIT: ignore `f_ready` for the first cycle (the engine drops ready one cycle after `wr`). Then wait for `f_ready`=1; that cycle `f_dout` holds the received byte.
- `f_format` changes only in an ISSUE cycle or on entry to CSH. It is never 000 between bytes of one transaction, so CS# stays low.
- DATA keeps a byte counter loaded with `len` and decremented per completed byte. Each completion produces `rvalid`=1, `rdata`=`f_dout` one cycle later (registered). The counter reaching 0 goes to CSH.
- `abort` is sampled at every byte completion, and is also latched if it pulses mid-byte. When set, the state goes to CSH after the current byte; no further `f_wr` is issued. A data byte completed in the abort cycle is still delivered.
- `start` while `busy` is ignored, as is `start` with `len`=0.
- `rst` mid-transaction: next cycle IDLE and `f_format`=000. The engine is left to finish its byte; CS# deasserts immediately.

## Timing
- `start` accepted → first `f_wr` (CMD) the next cycle; `busy` rises the same next cycle.
- Last byte `f_ready` → `rvalid` +1 cycle, → `f_format`=000 +1 cycle → `done` `CSH_CYCLES`+1 cycles later; `busy` falls with `done`.
- Bytes per transaction: SDR = 4+len; quad = 7+len.
- Gap between consecutive `f_wr` = engine byte time + 1 ISSUE cycle.
- No backpressure on `rdata`; the consumer must accept 1 byte per engine byte time.

## Structure
- Shared package: flash command opcodes (0x03, 0xEB), format encodings (FMT_OFF 000, FMT_SDR_T 010, FMT_SDR_R 011, FMT_DDR_T 100, FMT_QDR_T 110, FMT_QDR_R 111), and the state enum.
- Single module. The engine is instantiated by the parent, not inside this block.
- The bench uses a behavioural byte-engine model that reproduces one-cycle ready drop and configurable byte time.

## Test plan
- SDR, `addr`=0x012345, `len`=2, model returns 0xA5,0x5A.
  - Required: `f_din` sequence 03,01,23,45,FF,FF, all with format 010 except the data bytes at 011.
  - `rvalid`×2 with A5, 5A; then format 000 for 4 cycles; `done` once.
- Quad, `addr`=0xFFFFFF, `len`=1.
  - Required: EB@010, FF,FF,FF@110, 00@110, 2 dummies@111 with no `rvalid`, 1 data@111.
- `len`=0 start → no `f_wr`, `busy` stays 0. `start` pulsed during busy → ignored, and the byte count is unchanged.
- `abort` pulsed mid third data byte of `len`=10 → exactly 3 `rvalid`, then CSH, `done`.
- `rst` asserted while in ADDR → next cycle `f_format`=000, `busy`=0, `f_wr`=0. A fresh `start` afterwards completes normally.
- `prescale` changed mid-transaction → `f_prescale` holds the value sampled at `start`.
